// File: rtl/emu_seq_transactor.sv
// Emulation transactor: host byte bus -> wide DUT stimulus, stepped DUT clocking
// via dut_ce, and byte-addressable capture readback. EMU_MONITOR_LED_EN adds clk_LED.
module emu_seq_transactor #(
    parameter int STIM_BYTES = 4,
    parameter int OUT_BYTES  = 4,
    parameter int ADDR_W     = 3
) (
    input  logic                    clk_emu,
    input  logic                    rst_emu_n,
    input  logic [7:0]              Din_emu,
    output logic [7:0]              Dout_emu,
    input  logic [ADDR_W-1:0]       Addr_emu,
    input  logic                    load_emu,
    input  logic                    get_emu,
    input  logic                    step_emu,
    output logic                    busy_emu,
    output logic [8*STIM_BYTES-1:0] dut_stim,
    input  logic [8*OUT_BYTES-1:0]  dut_out,
    output logic                    dut_ce
`ifdef EMU_MONITOR_LED_EN
    ,
    output logic                    clk_LED
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, CAPT} state_t;

    state_t     state_q, state_d;
    logic [7:0] stim_q [STIM_BYTES];
    logic [7:0] cap_q  [OUT_BYTES];
    logic [8:0] cnt_q;
    logic [7:0] rd_byte;
    logic       do_load, do_get, do_step, do_host;

    // Out-of-range read addresses return zero.
    always_comb begin
        rd_byte = 8'h00;
        for (int k = 0; k < OUT_BYTES; k++) begin
            if (Addr_emu == ADDR_W'(k)) rd_byte = cap_q[k];
        end
    end

    always_comb begin
        state_d = state_q;
        do_load = 1'b0;
        do_get  = 1'b0;
        do_step = 1'b0;
        do_host = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_emu)      do_load = 1'b1;
                else if (get_emu)  do_get  = 1'b1;
                else if (step_emu) do_step = 1'b1;
                else               do_host = 1'b1;
                if (do_step) state_d = RUN;
            end
            RUN:     if (cnt_q == 9'd1) state_d = CAPT;
            CAPT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_emu or negedge rst_emu_n) begin
        if (!rst_emu_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_ff @(posedge clk_emu or negedge rst_emu_n) begin
        if (!rst_emu_n) begin
            for (int k = 0; k < STIM_BYTES; k++) stim_q[k] <= 8'h00;
            for (int k = 0; k < OUT_BYTES; k++)  cap_q[k]  <= 8'h00;
            dut_stim <= '0;
            Dout_emu <= 8'h00;
            dut_ce   <= 1'b0;
            busy_emu <= 1'b0;
            cnt_q    <= 9'd0;
        end else begin
            if (do_load) begin
                for (int k = 0; k < STIM_BYTES; k++) dut_stim[8*k +: 8] <= stim_q[k];
            end
            // Manual get and end-of-step capture share the same sampling.
            if (do_get || state_q == CAPT) begin
                for (int k = 0; k < OUT_BYTES; k++) cap_q[k] <= dut_out[8*k +: 8];
            end
            if (do_step) begin
                cnt_q    <= (Din_emu == 8'd0) ? 9'd256 : {1'b0, Din_emu};
                dut_ce   <= 1'b1;
                busy_emu <= 1'b1;
            end
            if (do_host) begin
                for (int k = 0; k < STIM_BYTES; k++) begin
                    if (Addr_emu == ADDR_W'(k)) stim_q[k] <= Din_emu;
                end
                Dout_emu <= rd_byte;
            end
            // dut_ce is high for every RUN cycle; drop it with the final pulse.
            if (state_q == RUN) begin
                cnt_q <= cnt_q - 9'd1;
                if (cnt_q == 9'd1) dut_ce <= 1'b0;
            end
            if (state_q == CAPT) busy_emu <= 1'b0;
        end
    end

`ifdef EMU_MONITOR_LED_EN
    logic [3:0] led_cnt_q;

    always_ff @(posedge clk_emu or negedge rst_emu_n) begin
        if (!rst_emu_n)  led_cnt_q <= 4'd0;
        else if (dut_ce) led_cnt_q <= led_cnt_q + 4'd1;
    end

    assign clk_LED = led_cnt_q[3];
`endif

endmodule
